// File: rtl/ham_deserializer.sv
// ---------------------------------------------------------------------------
// ham_deserializer
//
// Upstream stage of hamFix. Collects a serial Hamming(15,11) codeword,
// position 1 first, and builds the 4-bit syndrome on the fly. The presented
// word has the syndrome bits in the parity positions, which is the format
// hamFix expects: ham[1]=s0, ham[2]=s1, ham[4]=s2, ham[8]=s3. Every other
// position holds the received bit.
//
// A partial frame is discarded in two cases:
//   - the sender goes quiet for too long (timeout);
//   - a new start-of-frame arrives mid-frame (resync).
//
// Parameters
//   TIMEOUT     max idle cycles between accepted bits inside a frame (>=2)
//   SOF_RESYNC  1: sof inside a frame restarts it; 0: sof is a plain bit
//
// Ports
//   clock        single clock, all state updates on posedge
//   reset        synchronous, active-high
//   bit_valid    bit_in qualifies this cycle
//   bit_in       serial codeword bit
//   sof          start of frame (with bit_valid), marks position 1
//   ham[15:1]    assembled word with syndrome in positions 1,2,4,8
//   syndrome     {s3,s2,s1,s0} of the last completed frame
//   ham_valid    one-cycle pulse: ham/syndrome/err_flag updated
//   err_flag     syndrome != 0 for the last completed frame
//   frame_abort  one-cycle pulse: partial frame discarded
// ---------------------------------------------------------------------------
module ham_deserializer #(
  parameter int TIMEOUT    = 64,
  parameter bit SOF_RESYNC = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        sof,
  output logic [15:1] ham,
  output logic [3:0]  syndrome,
  output logic        ham_valid,
  output logic        err_flag,
  output logic        frame_abort
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [3:0]    pos;    // codeword position of the next expected bit
  logic [3:0]    acc;    // running syndrome: XOR of positions holding a 1
  logic [15:1]   shreg;  // received bits by codeword position
  logic [TW-1:0] tcnt;   // idle cycles since the last accepted bit

  logic [3:0]  acc_next;
  logic [15:1] word;

  // Syndrome after folding in the current bit. XOR-ing the position index
  // sets s_k exactly when bit k of the index is set, so no per-bit parity
  // trees are needed.
  always_comb begin
    acc_next = acc ^ (bit_in ? pos : 4'd0);
    word     = shreg;
    word[15] = bit_in;  // last bit bypasses shreg so the result is ready one cycle after it
    word[1]  = acc_next[0];
    word[2]  = acc_next[1];
    word[4]  = acc_next[2];
    word[8]  = acc_next[3];
  end

  // NOTE: every register here, shreg included, is reset so a reset mid-frame
  // leaves no stale bits visible; all state updates use non-blocking
  // assignments so each branch reads the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pos         <= 4'd0;
      acc         <= 4'd0;
      shreg       <= '0;
      tcnt        <= '0;
      ham         <= '0;
      syndrome    <= 4'd0;
      err_flag    <= 1'b0;
      ham_valid   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      ham_valid   <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          // Non-sof bits outside a frame are ignored.
          if (bit_valid && sof) begin
            shreg[1] <= bit_in;
            acc      <= {3'b000, bit_in};
            pos      <= 4'd2;
            tcnt     <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid && sof && SOF_RESYNC) begin
            // Drop the partial frame; this bit is position 1 of a new one.
            frame_abort <= 1'b1;
            shreg[1]    <= bit_in;
            acc         <= {3'b000, bit_in};
            pos         <= 4'd2;
            tcnt        <= '0;
          end else if (bit_valid) begin
            shreg[pos] <= bit_in;
            tcnt       <= '0;
            if (pos == 4'd15) begin
              ham       <= word;
              syndrome  <= acc_next;
              err_flag  <= |acc_next;
              ham_valid <= 1'b1;
              acc       <= 4'd0;
              pos       <= 4'd0;
              state     <= IDLE;
            end else begin
              acc <= acc_next;
              pos <= pos + 4'd1;
            end
          end else if (tcnt == TLAST) begin
            // TIMEOUT idle cycles in a row: give up on this frame.
            frame_abort <= 1'b1;
            acc         <= 4'd0;
            pos         <= 4'd0;
            tcnt        <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ham_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ham_deserializer
//
// Self-checking bench for ham_deserializer. Expected words come from a
// constant vector table or from an independent parity model; they are queued
// when a frame is sent and popped by a monitor on each ham_valid pulse.
// Hand-written sequences cover timeout, resync, back-to-back frames and
// reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_ham_deserializer;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        sof = 1'b0;
  logic [15:1] ham;
  logic [3:0]  syndrome;
  logic        ham_valid;
  logic        err_flag;
  logic        frame_abort;

  ham_deserializer #(.TIMEOUT(TIMEOUT), .SOF_RESYNC(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .sof         (sof),
    .ham         (ham),
    .syndrome    (syndrome),
    .ham_valid   (ham_valid),
    .err_flag    (err_flag),
    .frame_abort (frame_abort)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:1] ham;
    logic [3:0]  syn;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:1] bits;
    exp_t        exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          abort_cnt = 0;
  logic [15:1] last_ham = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: s_k is the parity of all received bits whose index has bit k set.
  function automatic exp_t model(input logic [15:1] b);
    exp_t       e;
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i <= 15; i++)
      for (int k = 0; k < 4; k++)
        if (i[k] && b[i]) s[k] = ~s[k];
    e.ham    = b;
    e.ham[1] = s[0];
    e.ham[2] = s[1];
    e.ham[4] = s[2];
    e.ham[8] = s[3];
    e.syn    = s;
    e.err    = |s;
    return e;
  endfunction

  // Monitor: samples 1 time unit after each active edge.
  always @(posedge clock) begin
    #1;
    if (ham_valid || frame_abort) check("pulse_exclusive", 32'(ham_valid & frame_abort), 0);
    if (frame_abort) abort_cnt++;
    if (ham_valid) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_ham_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ham", 32'(ham), 32'(e.ham));
        check("syndrome", 32'(syndrome), 32'(e.syn));
        check("err_flag", 32'(err_flag), 32'(e.err));
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic s);
    @(negedge clock);
    bit_valid = v;
    bit_in    = b;
    sof       = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:1] bits, input int first, input int last, input bit with_sof);
    for (int p = first; p <= last; p++)
      drive(1'b1, bits[p], with_sof && (p == first));
  endtask

  task automatic push(input exp_t e);
    sb.push_back(e);
    last_ham = e.ham;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ham"}, 32'(ham), 0);
    check({tag, "_syndrome"}, 32'(syndrome), 0);
    check({tag, "_err_flag"}, 32'(err_flag), 0);
    check({tag, "_ham_valid"}, 32'(ham_valid), 0);
    check({tag, "_frame_abort"}, 32'(frame_abort), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:1] f;
    logic [15:1] g;
    int          a0;
    int          v0;

    vecs[0] = '{bits: 15'h0000, exp: '{ham: 15'h0000, syn: 4'h0, err: 1'b0}};  // all zero
    vecs[1] = '{bits: 15'h0007, exp: '{ham: 15'h0004, syn: 4'h0, err: 1'b0}};  // bits 1,2,3
    vecs[2] = '{bits: 15'h0010, exp: '{ham: 15'h0019, syn: 4'h5, err: 1'b1}};  // bit 5 only
    vecs[3] = '{bits: 15'h4000, exp: '{ham: 15'h408B, syn: 4'hF, err: 1'b1}};  // bit 15 only
    vecs[4] = '{bits: 15'h7FFF, exp: '{ham: 15'h7F74, syn: 4'h0, err: 1'b0}};  // all ones

    // Reset state.
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Bits without sof while idle are ignored.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    check("stray_bits_no_valid", 32'(valid_cnt), 0);

    // Table vectors, with a latency check on each.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].exp);
      send_bits(vecs[i].bits, 1, 15, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("latency_valid", 32'(ham_valid), 1);
      drive(1'b0, 1'b0, 1'b0);
      check("valid_one_cycle", 32'(ham_valid), 0);
    end

    // Random frames with short random gaps between bits.
    for (int n = 0; n < 6; n++) begin
      f = 15'($urandom);
      push(model(f));
      for (int p = 1; p <= 15; p++) begin
        drive(1'b1, f[p], p == 1);
        if (p < 15) idle($urandom_range(0, 3));
      end
      idle(2);
    end
    check("random_all_consumed", 32'(sb.size()), 0);

    // Gap of TIMEOUT-1 idle cycles is tolerated.
    a0 = abort_cnt;
    f  = 15'($urandom);
    push(model(f));
    send_bits(f, 1, 7, 1'b1);
    idle(TIMEOUT - 1);
    send_bits(f, 8, 15, 1'b0);
    idle(2);
    check("no_abort_below_timeout", 32'(abort_cnt), 32'(a0));
    check("long_gap_frame_done", 32'(sb.size()), 0);

    // 7 bits then silence: one abort, no completion, ham held.
    a0 = abort_cnt;
    v0 = valid_cnt;
    g  = 15'($urandom);
    send_bits(g, 1, 7, 1'b1);
    idle(TIMEOUT + 3);
    check("timeout_abort_once", 32'(abort_cnt), 32'(a0 + 1));
    check("timeout_no_valid", 32'(valid_cnt), 32'(v0));
    check("timeout_ham_held", 32'(ham), 32'(last_ham));

    // Clean frame after the timeout.
    f = 15'h0010;
    push(model(f));
    send_bits(f, 1, 15, 1'b1);
    idle(2);
    check("post_timeout_frame", 32'(sb.size()), 0);

    // Resync: sof in place of bit 9, then 14 more bits of the new frame.
    a0 = abort_cnt;
    v0 = valid_cnt;
    f  = 15'($urandom);
    g  = 15'($urandom);
    send_bits(f, 1, 8, 1'b1);
    push(model(g));
    send_bits(g, 1, 15, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("resync_latency_valid", 32'(ham_valid), 1);
    idle(2);
    check("resync_abort_once", 32'(abort_cnt), 32'(a0 + 1));
    check("resync_one_valid", 32'(valid_cnt), 32'(v0 + 1));

    // Back-to-back frames, then reset at bit 6 of a third frame.
    a0 = abort_cnt;
    v0 = valid_cnt;
    f  = 15'($urandom);
    push(model(f));
    send_bits(f, 1, 15, 1'b1);
    push(model(15'h0010));
    send_bits(15'h0010, 1, 15, 1'b1);
    g = 15'($urandom);
    send_bits(g, 1, 5, 1'b1);
    check("b2b_ham_before_reset", 32'(ham), 32'h0019);
    @(negedge clock);
    reset     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = g[6];
    sof       = 1'b0;
    @(negedge clock);
    reset     = 1'b0;
    bit_valid = 1'b0;
    check_outputs_zero("midframe_reset");
    check("b2b_two_valids", 32'(valid_cnt), 32'(v0 + 2));
    send_bits(g, 7, 15, 1'b0);
    idle(3);
    check("third_frame_dropped", 32'(valid_cnt), 32'(v0 + 2));
    check("no_abort_on_reset", 32'(abort_cnt), 32'(a0));
    check("ham_zero_after_reset", 32'(ham), 0);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
